// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: owns the PC,
// fetches over a req/ack handshake and pulses datapath strobes in EXECUTE.
module cpu_control_unit #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 16,
    parameter int RESET_PC    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mem_ack,
    input  logic               equal,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [ADDR_W-1:0]  contador,
    output logic [3:0]         opcode,
    output logic [7:0]         imm,
    output logic               ld_a,
    output logic               ld_b,
    output logic [1:0]         alu_op,
    output logic               flag_we,
    output logic               halted,
    output logic               error
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JEQ = 4'h7;
    localparam logic [3:0] OP_JNE = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [WAIT_W-1:0]   wait_cnt;

    assign mem_addr = contador;
    assign opcode   = ir[INSTR_W-1 -: 4];
    assign imm      = ir[7:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_FETCH;
            contador <= ADDR_W'(RESET_PC);
            ir       <= '0;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            ld_a     <= 1'b0;
            ld_b     <= 1'b0;
            alu_op   <= 2'b00;
            flag_we  <= 1'b0;
            halted   <= 1'b0;
            error    <= 1'b0;
        end else begin
            // strobes live for exactly one cycle
            ld_a    <= 1'b0;
            ld_b    <= 1'b0;
            alu_op  <= 2'b00;
            flag_we <= 1'b0;
            case (state)
                S_FETCH: begin
                    // first cycle out of reset only raises the request; acks before that are ignored
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        ir       <= instr_in;
                        wait_cnt <= '0;
                        mem_req  <= 1'b0;
                        state    <= S_DECODE;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        halted  <= 1'b1;
                        error   <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    contador <= contador + ADDR_W'(1);
                    state    <= S_EXECUTE;
                    case (opcode)
                        OP_LDA: ld_a <= 1'b1;
                        OP_LDB: ld_b <= 1'b1;
                        OP_ADD: begin
                            ld_a   <= 1'b1;
                            alu_op <= 2'b01;
                        end
                        OP_SUB: begin
                            ld_a   <= 1'b1;
                            alu_op <= 2'b10;
                        end
                        OP_CMP: flag_we <= 1'b1;
                        OP_NOP, OP_JMP, OP_JEQ, OP_JNE, OP_HLT: ;
                        default: begin
                            halted <= 1'b1;
                            error  <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    state   <= S_FETCH;
                    mem_req <= 1'b1;
                    case (opcode)
                        OP_JMP: contador <= ir[ADDR_W-1:0];
                        OP_JEQ: if (equal)  contador <= ir[ADDR_W-1:0];
                        OP_JNE: if (!equal) contador <= ir[ADDR_W-1:0];
                        OP_HLT: begin
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                            state   <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level reference model checked every
// cycle, plus directed programs with hand-computed timing expectations.
module tb_cpu_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_in;
    logic        mem_ack;
    logic        equal;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [11:0] contador;
    logic [3:0]  opcode;
    logic [7:0]  imm;
    logic        ld_a, ld_b, flag_we, halted, error;
    logic [1:0]  alu_op;

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .mem_ack(mem_ack), .equal(equal),
        .mem_req(mem_req), .mem_addr(mem_addr), .contador(contador), .opcode(opcode),
        .imm(imm), .ld_a(ld_a), .ld_b(ld_b), .alu_op(alu_op), .flag_we(flag_we),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // instruction memory and responder with programmable wait states
    logic [15:0] mem [0:4095];
    int          ack_delay = 0;
    int          wctr = 0;
    logic        resp_ack = 1'b0;
    logic [15:0] resp_instr = 16'h0;
    logic        force_ack = 1'b0;
    logic [15:0] force_instr = 16'h0;

    assign mem_ack  = resp_ack | force_ack;
    assign instr_in = force_ack ? force_instr : resp_instr;

    always @(negedge clk) begin
        if (rst && mem_req) begin
            if (wctr >= ack_delay) begin
                resp_ack   = 1'b1;
                resp_instr = mem[mem_addr];
            end else begin
                resp_ack = 1'b0;
            end
            wctr++;
        end else begin
            resp_ack = 1'b0;
            wctr     = 0;
        end
    end

    // A/B datapath driven by the DUT strobes; supplies the equal flag
    logic [7:0] dp_a, dp_b;
    logic       dp_eq;
    assign equal = dp_eq;
    always @(posedge clk) begin
        if (!rst) begin
            dp_a  <= 8'h0;
            dp_b  <= 8'h0;
            dp_eq <= 1'b0;
        end else begin
            if (ld_b) dp_b <= imm;
            if (ld_a) begin
                case (alu_op)
                    2'b00:   dp_a <= imm;
                    2'b01:   dp_a <= dp_a + dp_b;
                    default: dp_a <= dp_a - dp_b;
                endcase
            end
            if (flag_we) dp_eq <= (dp_a == dp_b);
        end
    end

    int cyc = 0;
    always @(posedge clk) begin
        if (!rst) cyc = 0;
        else      cyc++;
    end

    // Instruction-level reference: tracks ISA state (PC, A, B, eq) and the
    // number of edges since the fetch handshake; strobes belong to the cycle
    // one edge after the handshake, the ISA effect lands one edge later.
    logic [11:0] m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_a, m_b;
    logic        m_eq, m_halt, m_err, m_fetch, m_started;
    int          m_age, m_wait;
    logic        e_lda, e_ldb, e_fw;
    logic [1:0]  e_alu;

    always @(posedge clk) begin
        if (!rst) begin
            m_pc = 12'h0; m_ir = 16'h0; m_a = 8'h0; m_b = 8'h0; m_eq = 1'b0;
            m_halt = 1'b0; m_err = 1'b0; m_fetch = 1'b0; m_started = 1'b0;
            m_age = -1; m_wait = 0;
            e_lda = 1'b0; e_ldb = 1'b0; e_fw = 1'b0; e_alu = 2'b00;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_fetch   = 1'b1;
        end else if (m_halt) begin
            m_age = -1;
        end else if (m_fetch) begin
            if (mem_ack) begin
                m_ir = instr_in; m_fetch = 1'b0; m_age = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == 15) begin
                    m_halt = 1'b1; m_err = 1'b1;
                end
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_pc  = m_pc + 12'h1;
                e_lda = 1'b0; e_ldb = 1'b0; e_fw = 1'b0; e_alu = 2'b00;
                case (m_ir[15:12])
                    4'h1: e_lda = 1'b1;
                    4'h2: e_ldb = 1'b1;
                    4'h3: begin e_lda = 1'b1; e_alu = 2'b01; end
                    4'h4: begin e_lda = 1'b1; e_alu = 2'b10; end
                    4'h5: e_fw = 1'b1;
                    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin m_halt = 1'b1; m_err = 1'b1; end
                    default: ;
                endcase
            end else begin
                m_fetch = 1'b1;
                m_age   = -1;
                case (m_ir[15:12])
                    4'h1: m_a = m_ir[7:0];
                    4'h2: m_b = m_ir[7:0];
                    4'h3: m_a = m_a + m_b;
                    4'h4: m_a = m_a - m_b;
                    4'h5: m_eq = (m_a == m_b);
                    4'h6: m_pc = m_ir[11:0];
                    4'h7: if (m_eq)  m_pc = m_ir[11:0];
                    4'h8: if (!m_eq) m_pc = m_ir[11:0];
                    4'hF: begin m_halt = 1'b1; m_fetch = 1'b0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", contador, m_pc);
            chk("mem_addr", mem_addr, m_pc);
            chk("mem_req", mem_req, m_fetch && !m_halt);
            chk("halted_error", {halted, error}, {m_halt, m_err});
            chk("strobes", {ld_a, ld_b, alu_op, flag_we},
                (m_age == 1 && !m_halt) ? {e_lda, e_ldb, e_alu, e_fw} : 5'b0);
            chk("ir_fields", {opcode, imm}, {m_ir[15:12], m_ir[7:0]});
        end
    end

    // directed-run event recorder
    int fw_cyc, halt_cyc, addr_cyc, strobe_cnt;
    logic [7:0]  lda_imm;
    logic [11:0] watch_addr;

    task automatic clear_rec();
        fw_cyc = 0; halt_cyc = 0; addr_cyc = 0; strobe_cnt = 0; lda_imm = 8'h0;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clk);
            if (flag_we && fw_cyc == 0) fw_cyc = cyc;
            if (ld_a && alu_op == 2'b00) lda_imm = imm;
            if (ld_a || ld_b || flag_we) strobe_cnt++;
            if (halted && halt_cyc == 0) halt_cyc = cyc;
            if (mem_req && mem_addr == watch_addr && addr_cyc == 0) addr_cyc = cyc;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_contador", contador, 12'h000);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_error", error, 1'b0);
        clear_rec();
    endtask

    task automatic release_rst();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_mem_req", mem_req, 1'b1);
        chk("rel_mem_addr", mem_addr, 12'h000);
    endtask

    initial begin
        fill_mem();
        do_reset();

        // LDA 5; LDB 5; CMP; JEQ 0x010; @0x010 HLT
        mem[0] = 16'h1005; mem[1] = 16'h2005; mem[2] = 16'h5000; mem[3] = 16'h7010;
        mem[12'h010] = 16'hF000;
        ack_delay = 0; watch_addr = 12'h010;
        release_rst();
        watch(20);
        chk("t2_lda_imm", lda_imm, 8'h05);
        chk("t2_flag_we_cycle", fw_cyc, 9);
        chk("t2_jeq_target_fetch_cycle", addr_cyc, 13);
        chk("t2_halt_cycle", halt_cyc, 16);
        chk("t2_error", error, 1'b0);
        chk("t2_contador", contador, 12'h011);

        // three wait states per fetch: 6 cycles per instruction
        fill_mem();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000;
        do_reset();
        ack_delay = 3; watch_addr = 12'h001;
        release_rst();
        watch(25);
        chk("t3_second_fetch_cycle", addr_cyc, 7);
        chk("t3_halt_cycle", halt_cyc, 19);
        chk("t3_error", error, 1'b0);

        // no ack at all: timeout halt
        do_reset();
        ack_delay = 1000;
        release_rst();
        watch(20);
        chk("t3_timeout_halt_cycle", halt_cyc, 16);
        chk("t3_timeout_error", error, 1'b1);
        chk("t3_timeout_mem_req", mem_req, 1'b0);

        // illegal opcode 0xA at 0x004
        fill_mem();
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        mem[4] = 16'hA000;
        do_reset();
        ack_delay = 0;
        release_rst();
        watch(20);
        chk("t4_halt_cycle", halt_cyc, 15);
        chk("t4_error", error, 1'b1);
        chk("t4_contador", contador, 12'h005);
        chk("t4_strobe_count", strobe_cnt, 0);

        // JMP 0xFFF; NOP at 0xFFF wraps back to 0x000
        fill_mem();
        mem[0] = 16'h6FFF; mem[12'hFFF] = 16'h0000;
        do_reset();
        watch_addr = 12'h000;
        release_rst();
        watch(12);
        chk("t5_wrap_fetch_cycle", addr_cyc, 7);
        chk("t5_not_halted", halted, 1'b0);

        // reset while a fetch is pending; ack during/just after reset ignored
        fill_mem();
        mem[0] = 16'h0000; mem[1] = 16'hF000;
        do_reset();
        ack_delay = 0;
        release_rst();
        watch(2);
        ack_delay = 1000;
        watch(3);
        chk("t6_pending_addr", mem_addr, 12'h001);
        chk("t6_pending_req", mem_req, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_req_dropped", mem_req, 1'b0);
        chk("t6_contador_reset", contador, 12'h000);
        force_instr = 16'h6123;
        force_ack   = 1'b1;
        @(negedge clk);
        ack_delay = 0;
        rst = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        chk("t6_req_after_release", mem_req, 1'b1);
        chk("t6_contador_after_release", contador, 12'h000);
        clear_rec();
        watch(10);
        chk("t6_halt_cycle", halt_cyc, 7);
        chk("t6_error", error, 1'b0);
        chk("t6_contador", contador, 12'h002);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
